rr_grant_ctrl: RTL and testbench

- Round-robin arbiter sharing one 7-segment index display among 8 requesters on the nvboard lab top.
- Produces a one-hot grant, the 3-bit index of the current owner, and a registered active-low 7-segment pattern of that index.
- A hold-limit counter bounds ownership so no requester starves the others.

---
 rtl/rr_grant_ctrl.sv | 126 ++++++++++++
 tb/tb_rr_grant_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter that shares one 7-segment index display among 8 requesters.
// Define FIXED_PRIO_EN to get fixed priority instead, where the highest request index wins.
module rr_grant_ctrl #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       busy,
   output logic [6:0] dig
);

   localparam int CNT_W = $clog2(MAX_HOLD) + 1;
   localparam logic [6:0] DIG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t           r_state;
   logic [7:0]       r_gnt;
   logic [2:0]       r_idx;
   logic [CNT_W-1:0] r_hold;
   logic [6:0]       r_dig;
   logic             w_found;
   logic [2:0]       w_win;
`ifndef FIXED_PRIO_EN
   logic [2:0]       r_ptr;
   logic [2:0]       w_cand;
`endif

   function automatic logic [6:0] segOf(input logic [2:0] v);
      case (v)
         3'd0:    segOf = 7'b1000000;
         3'd1:    segOf = 7'b1111001;
         3'd2:    segOf = 7'b0100100;
         3'd3:    segOf = 7'b0110000;
         3'd4:    segOf = 7'b0011001;
         3'd5:    segOf = 7'b0010010;
         3'd6:    segOf = 7'b0000010;
         default: segOf = 7'b1111000;
      endcase
   endfunction

`ifdef FIXED_PRIO_EN
   always_comb begin
      w_found = |req;
      w_win   = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (req[k]) w_win = 3'(k);
      end
   end
`else
   // Scan offsets from far to near so the request closest to r_ptr overwrites the rest.
   always_comb begin
      w_found = |req;
      w_win   = 3'd0;
      w_cand  = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         w_cand = r_ptr + 3'(k);
         if (req[w_cand]) w_win = w_cand;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_gnt   <= 8'd0;
         r_idx   <= 3'd0;
         r_hold  <= '0;
         r_dig   <= DIG_BLANK;
`ifndef FIXED_PRIO_EN
         r_ptr   <= 3'd0;
`endif
      end else if (!en) begin
         r_state <= IDLE;
         r_gnt   <= 8'd0;
         r_idx   <= 3'd0;
         r_hold  <= '0;
         r_dig   <= DIG_BLANK;
      end else begin
         case (r_state)
            IDLE, RELEASE: begin
               if (w_found) begin
                  r_state <= GRANT;
                  r_gnt   <= 8'b1 << w_win;
                  r_idx   <= w_win;
                  r_hold  <= CNT_W'(1);
                  r_dig   <= segOf(w_win);
               end else begin
                  r_state <= IDLE;
                  r_gnt   <= 8'd0;
                  r_idx   <= 3'd0;
                  r_hold  <= '0;
                  r_dig   <= DIG_BLANK;
               end
            end
            GRANT: begin
               // r_idx is kept through RELEASE and only cleared when IDLE is entered.
               if (!req[r_idx] || (r_hold == CNT_W'(MAX_HOLD))) begin
                  r_state <= RELEASE;
                  r_gnt   <= 8'd0;
                  r_hold  <= '0;
                  r_dig   <= DIG_BLANK;
`ifndef FIXED_PRIO_EN
                  r_ptr   <= r_idx + 3'd1;
`endif
               end else begin
                  r_hold  <= r_hold + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign gnt_idx   = r_idx;
   assign gnt_valid = |r_gnt;
   assign busy      = (r_state != IDLE);
   assign dig       = r_dig;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: a behavioural model pushes the expected outputs for each edge,
// and they are popped and compared once the DUT has clocked.
module tb_rr_grant_ctrl;

   localparam int MAXH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] req = 8'd0;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       busy;
   logic [6:0] dig;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       busy;
      logic [6:0] dig;
   } exp_t;

   exp_t expQ[$];

   // Model state: 0 = IDLE, 1 = GRANT, 2 = RELEASE
   int         mState = 0;
   logic [2:0] mPtr = 3'd0;
   int         mHold = 0;
   logic [2:0] mIdx = 3'd0;
   logic [7:0] mGnt = 8'd0;

   logic [6:0] segTab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

   rr_grant_ctrl #(.MAX_HOLD(MAXH)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .busy(busy), .dig(dig)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic [7:0] r);
      en  = e;
      req = r;
   endtask

   function automatic logic [2:0] pickWinner(input logic [7:0] r, input logic [2:0] p);
      logic [15:0] dbl;
      logic [2:0]  w;
      logic        hit;
      w   = 3'd0;
      hit = 1'b0;
`ifdef FIXED_PRIO_EN
      dbl = 16'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!hit && r[i]) begin
            w   = 3'(i);
            hit = 1'b1;
         end
      end
`else
      dbl = {r, r} >> p;
      for (int i = 0; i < 8; i++) begin
         if (!hit && dbl[i]) begin
            w   = 3'((int'(p) + i) % 8);
            hit = 1'b1;
         end
      end
`endif
      return w;
   endfunction

   task automatic modelGoIdle();
      mState = 0;
      mGnt   = 8'd0;
      mIdx   = 3'd0;
      mHold  = 0;
   endtask

   task automatic modelStep();
      logic [2:0] w;
      if (!en) begin
         modelGoIdle();
      end else if (mState == 1) begin
         if (!req[mIdx] || mHold == MAXH) begin
            mState = 2;
            mGnt   = 8'd0;
            mHold  = 0;
            mPtr   = mIdx + 3'd1;
         end else begin
            mHold++;
         end
      end else if (req != 8'd0) begin
         w      = pickWinner(req, mPtr);
         mState = 1;
         mIdx   = w;
         mGnt   = 8'd0;
         mGnt[w] = 1'b1;
         mHold  = 1;
      end else begin
         modelGoIdle();
      end
   endtask

   // One clock edge: predict, let the DUT clock, then compare every output.
   task automatic tick();
      exp_t e;
      exp_t got;
      modelStep();
      e.gnt   = mGnt;
      e.idx   = mIdx;
      e.valid = (mGnt != 8'd0);
      e.busy  = (mState != 0);
      e.dig   = (mGnt != 8'd0) ? segTab[mIdx] : 7'b1111111;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      got = expQ.pop_front();
      checkOutput("gnt", 32'(gnt), 32'(got.gnt));
      checkOutput("gnt_idx", 32'(gnt_idx), 32'(got.idx));
      checkOutput("gnt_valid", 32'(gnt_valid), 32'(got.valid));
      checkOutput("busy", 32'(busy), 32'(got.busy));
      checkOutput("dig", 32'(dig), 32'(got.dig));
   endtask

   // Asserted between edges so the asynchronous clear is observed without a clock.
   task automatic doReset();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_gnt", 32'(gnt), 32'h0);
      checkOutput("rst_dig", 32'(dig), 32'h7f);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_idx", 32'(gnt_idx), 32'h0);
      checkOutput("rst_valid", 32'(gnt_valid), 32'h0);
      modelGoIdle();
      mPtr = 3'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] gHist [40];
      int         seqIdx [$];
      logic       prevValid;
      int         runLen;

      $display("[TB] starting rr_grant_ctrl bench");
      applyStimulus(1'b0, 8'd0);
      @(posedge clk);
      #1;
      doReset();

      // Reset in the middle of a grant to requester 5, then a fresh grant to requester 0.
      applyStimulus(1'b1, 8'h20);
      tick();
      checkOutput("idx5_gnt", 32'(gnt), 32'h20);
      doReset();
      applyStimulus(1'b1, 8'h01);
      tick();
      checkOutput("post_rst_gnt", 32'(gnt), 32'h01);
      checkOutput("post_rst_dig", 32'(dig), 32'h40);

      // Two requesters held constantly: ownership alternates after each timeout.
      doReset();
      applyStimulus(1'b1, 8'h81);
      prevValid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (gnt_valid && !prevValid) seqIdx.push_back(int'(gnt_idx));
         prevValid = gnt_valid;
      end
      checkOutput("rr_count", 32'(seqIdx.size() >= 3), 32'd1);
`ifdef FIXED_PRIO_EN
      checkOutput("rr_first", 32'(seqIdx[0]), 32'd7);
      checkOutput("rr_second", 32'(seqIdx[1]), 32'd7);
`else
      checkOutput("rr_first", 32'(seqIdx[0]), 32'd0);
      checkOutput("rr_second", 32'(seqIdx[1]), 32'd7);
      checkOutput("rr_third", 32'(seqIdx[2]), 32'd0);
`endif

      // Owner releases; the search then restarts just past the old owner.
      doReset();
      applyStimulus(1'b1, 8'h08);
      for (int i = 0; i < 4; i++) tick();
      applyStimulus(1'b1, 8'h00);
      tick();
      checkOutput("rel_bubble", 32'(gnt), 32'h0);
      applyStimulus(1'b1, 8'h09);
      tick();
`ifdef FIXED_PRIO_EN
      checkOutput("rel_next_idx", 32'(gnt_idx), 32'd3);
`else
      checkOutput("rel_next_idx", 32'(gnt_idx), 32'd0);
      checkOutput("rel_next_gnt", 32'(gnt), 32'h01);
`endif

      // A single requester held forever is cut off after MAXH cycles.
      doReset();
      applyStimulus(1'b1, 8'h04);
      for (int i = 0; i < 40; i++) begin
         tick();
         gHist[i] = gnt;
      end
      runLen = 0;
      for (int i = 0; i < 17; i++) if (gHist[i] == 8'h04) runLen++;
      checkOutput("to_runlen", 32'(runLen), 32'(MAXH));
      checkOutput("to_last", 32'(gHist[MAXH-1]), 32'h04);
      checkOutput("to_bubble", 32'(gHist[MAXH]), 32'h00);
      checkOutput("to_regrant", 32'(gHist[MAXH+1]), 32'h04);

      // Enable dropped mid-grant; the pointer survives.
      doReset();
      applyStimulus(1'b1, 8'h40);
      tick();
      checkOutput("en_gnt", 32'(gnt), 32'h40);
      applyStimulus(1'b0, 8'h40);
      tick();
      checkOutput("en_off_gnt", 32'(gnt), 32'h0);
      checkOutput("en_off_busy", 32'(busy), 32'h0);
      checkOutput("en_off_dig", 32'(dig), 32'h7f);
      applyStimulus(1'b1, 8'h41);
      tick();
`ifdef FIXED_PRIO_EN
      checkOutput("en_on_idx", 32'(gnt_idx), 32'd6);
`else
      checkOutput("en_on_idx", 32'(gnt_idx), 32'd0);
`endif

`ifdef FIXED_PRIO_EN
      doReset();
      applyStimulus(1'b1, 8'hFF);
      for (int i = 0; i < 40; i++) begin
         tick();
         gHist[i] = gnt;
      end
      checkOutput("fp_bubble", 32'(gHist[MAXH]), 32'h00);
      checkOutput("fp_regrant", 32'(gHist[MAXH+1]), 32'h80);
      checkOutput("fp_dig", 32'(dig), 32'h78);
`endif

      // Random traffic, mostly enabled, with occasional drops of enable.
      doReset();
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 15) != 0), 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
         tick();
      end
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 5) == 0) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
